// File: rtl/blackparrot_chip_pkg.sv
// Shared chip-level constants and types for the unicore DRAM path.
//   dram_interleave_bit_gp   : address bit choosing the DRAM bridge (64 B blocks)
//   dram_max_outstanding_gp  : depth of the splitter's response-order tracking
//   bp_dram_ch_id_t          : identifies one of the two DRAM bridges
package blackparrot_chip_pkg;

    localparam int dram_interleave_bit_gp  = 6;
    localparam int dram_max_outstanding_gp = 8;

    typedef logic bp_dram_ch_id_t;

endpackage

// File: rtl/bp_dram_interleave_order_fifo.sv
// Order FIFO for the DRAM interleave splitter: remembers which channel each
// accepted command went to so responses can be returned in request order.
// The head entry is read combinationally; there is no write-to-read bypass,
// so an entry pushed on an edge is visible as head from the next cycle on.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   push_i, data_i   : enqueue a channel id (ignored when full)
//   pop_i            : dequeue the head entry (ignored when empty)
//   full_o, empty_o  : occupancy flags
//   head_o           : channel id at the front
//   count_o          : number of stored entries
module bp_dram_interleave_order_fifo
    import blackparrot_chip_pkg::*;
#(
    parameter  int els_p     = dram_max_outstanding_gp,
    localparam int ptr_w_lp  = $clog2(els_p),
    localparam int cnt_w_lp  = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                push_i,
    input  bp_dram_ch_id_t      data_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output bp_dram_ch_id_t      head_o,
    output logic [cnt_w_lp-1:0] count_o
);

    bp_dram_ch_id_t      r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    assign full_o  = (r_count == cnt_w_lp'(els_p));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Storage carries no reset: only entries between the pointers are read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // els_p is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_w_lp'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_w_lp'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + cnt_w_lp'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - cnt_w_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bp_dram_interleave_splitter.sv
// Splits the unicore memory-command stream across two DRAM bridges by one
// address bit and merges their responses back in original request order.
// Ports:
//   clk_i, reset_n_i                      : clock, asynchronous active-low reset
//   cmd_i/cmd_addr_i/cmd_v_i/cmd_ready_and_o : incoming command (ready-and)
//   ch_cmd_o/ch_cmd_v_o/ch_cmd_ready_and_i   : per-bridge command outputs
//   ch_resp_i/ch_resp_v_i/ch_resp_yumi_o     : per-bridge responses
//   resp_o/resp_v_o/resp_yumi_i              : merged, in-order response
//   outstanding_o                            : per-bridge outstanding count
//   idle_o                                   : nothing outstanding
module bp_dram_interleave_splitter
    import blackparrot_chip_pkg::*;
#(
    parameter  int msg_width_p      = 0,
    parameter  int addr_width_p     = 40,
    parameter  int interleave_bit_p = dram_interleave_bit_gp,
    parameter  int els_p            = dram_max_outstanding_gp,
    // msg_width_p has no usable default; clamp so an unset value still elaborates.
    localparam int msg_w_lp         = (msg_width_p > 0) ? msg_width_p : 1,
    localparam int cnt_w_lp         = $clog2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [msg_w_lp-1:0]      cmd_i,
    input  logic [addr_width_p-1:0]  cmd_addr_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_and_o,
    output logic [1:0][msg_w_lp-1:0] ch_cmd_o,
    output logic [1:0]               ch_cmd_v_o,
    input  logic [1:0]               ch_cmd_ready_and_i,
    input  logic [1:0][msg_w_lp-1:0] ch_resp_i,
    input  logic [1:0]               ch_resp_v_i,
    output logic [1:0]               ch_resp_yumi_o,
    output logic [msg_w_lp-1:0]      resp_o,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [1:0][cnt_w_lp-1:0] outstanding_o,
    output logic                     idle_o
);

    bp_dram_ch_id_t      w_sel;
    bp_dram_ch_id_t      w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_pop;
    logic [cnt_w_lp-1:0] w_fifo_count;
    logic                w_unused_addr;

    // Only the interleave bit steers; the full address travels inside cmd_i.
    assign w_unused_addr = ^cmd_addr_i;
    assign w_sel         = cmd_addr_i[interleave_bit_p];

    // Ready is gated by full alone (never by a same-cycle pop), keeping
    // resp_yumi_i out of the command-ready path. reset_n_i gating forces
    // handshakes low for the whole reset window, not just after an edge.
    assign cmd_ready_and_o = reset_n_i & ~w_full & ch_cmd_ready_and_i[w_sel];
    assign w_accept        = cmd_v_i & cmd_ready_and_o;

    assign resp_o   = ch_resp_i[w_head];
    assign resp_v_o = reset_n_i & ~w_empty & ch_resp_v_i[w_head];
    // A yumi without a valid response is dropped rather than popping order state.
    assign w_pop    = resp_yumi_i & resp_v_o;
    assign idle_o   = (w_fifo_count == '0);

    bp_dram_interleave_order_fifo #(
        .els_p (els_p)
    ) u_order_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (w_accept),
        .data_i    (w_sel),
        .pop_i     (w_pop),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .head_o    (w_head),
        .count_o   (w_fifo_count)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [cnt_w_lp-1:0] r_outstanding;
        logic                w_inc;
        logic                w_dec;

        assign ch_cmd_o[gi]       = cmd_i;
        assign ch_cmd_v_o[gi]     = reset_n_i & cmd_v_i & ~w_full & (w_sel == 1'(gi));
        assign ch_resp_yumi_o[gi] = w_pop & (w_head == 1'(gi));

        assign w_inc = w_accept & (w_sel == 1'(gi));
        assign w_dec = w_pop & (w_head == 1'(gi));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_outstanding <= '0;
            end else if (w_inc && !w_dec) begin
                r_outstanding <= r_outstanding + cnt_w_lp'(1);
            end else if (w_dec && !w_inc) begin
                r_outstanding <= r_outstanding - cnt_w_lp'(1);
            end
        end

        assign outstanding_o[gi] = r_outstanding;
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(resp_yumi_i && !resp_v_o));

endmodule

// File: tb/tb_bp_dram_interleave_splitter.sv
module tb_bp_dram_interleave_splitter;

    localparam int MW = 16;
    localparam int AW = 40;
    localparam int IB = 6;
    localparam int EL = 8;
    localparam int CW = $clog2(EL + 1);
    localparam logic [MW-1:0] RESP_X = 16'h5A3C;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [MW-1:0]      cmd = '0;
    logic [AW-1:0]      addr = '0;
    logic               cmd_v = 1'b0;
    logic               cmd_rdy;
    logic [1:0][MW-1:0] ch_cmd;
    logic [1:0]         ch_cmd_v;
    logic [1:0]         ch_cmd_rdy = 2'b00;
    logic [1:0][MW-1:0] ch_resp = '0;
    logic [1:0]         ch_resp_v = 2'b00;
    logic [1:0]         ch_resp_yumi;
    logic [MW-1:0]      resp;
    logic               resp_v;
    logic               resp_yumi = 1'b0;
    logic [1:0][CW-1:0] outst;
    logic               idle;

    always #5 clk = ~clk;

    bp_dram_interleave_splitter #(
        .msg_width_p      (MW),
        .addr_width_p     (AW),
        .interleave_bit_p (IB),
        .els_p            (EL)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .cmd_i              (cmd),
        .cmd_addr_i         (addr),
        .cmd_v_i            (cmd_v),
        .cmd_ready_and_o    (cmd_rdy),
        .ch_cmd_o           (ch_cmd),
        .ch_cmd_v_o         (ch_cmd_v),
        .ch_cmd_ready_and_i (ch_cmd_rdy),
        .ch_resp_i          (ch_resp),
        .ch_resp_v_i        (ch_resp_v),
        .ch_resp_yumi_o     (ch_resp_yumi),
        .resp_o             (resp),
        .resp_v_o           (resp_v),
        .resp_yumi_i        (resp_yumi),
        .outstanding_o      (outst),
        .idle_o             (idle)
    );

    // Reference model: one queue of accepted commands in request order, plus
    // a per-bridge queue of pending responses with the cycle they become ready.
    typedef struct packed {
        logic          ch;
        logic [MW-1:0] d;
    } ord_t;
    typedef struct packed {
        logic [MW-1:0] d;
        int            due;
    } br_t;

    ord_t exp_q[$];
    br_t  br0[$];
    br_t  br1[$];
    int   lat_lo[2];
    int   lat_hi[2];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accepted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, let outputs settle, compare, then advance the model.
    task automatic run_cycle(input logic cv, input logic [AW-1:0] a, input logic [1:0] rdy,
                             input int yumi_pct);
        logic       sel;
        logic       exp_rdy;
        logic       exp_rv;
        logic       pop;
        logic       acc;
        logic [1:0] exp_cv;
        logic [1:0] exp_y;
        int         n0;
        int         n1;
        ord_t       f;
        br_t        nb;
        f = '0;
        @(negedge clk);
        cmd_v      = cv;
        addr       = a;
        cmd        = {cyc[7:0], 8'($urandom)};
        ch_cmd_rdy = rdy;
        ch_resp_v  = 2'b00;
        if (br0.size() > 0) begin
            ch_resp[0]   = br0[0].d ^ RESP_X;
            ch_resp_v[0] = (br0[0].due <= cyc);
        end
        if (br1.size() > 0) begin
            ch_resp[1]   = br1[0].d ^ RESP_X;
            ch_resp_v[1] = (br1[0].due <= cyc);
        end
        resp_yumi = 1'b0;
        #1;
        sel     = a[IB];
        exp_rdy = rdy[sel] && (exp_q.size() < EL);
        exp_cv  = (cv && exp_q.size() < EL) ? (2'b01 << sel) : 2'b00;
        exp_rv  = 1'b0;
        if (exp_q.size() > 0) begin
            f      = exp_q[0];
            exp_rv = ch_resp_v[f.ch];
        end
        pop       = exp_rv && (int'($urandom_range(99)) < yumi_pct);
        resp_yumi = pop;
        #1;
        exp_y = pop ? (2'b01 << f.ch) : 2'b00;
        n0 = 0;
        n1 = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i].ch) n1++;
            else n0++;
        end
        check("cmd_ready", 32'(cmd_rdy), 32'(exp_rdy));
        check("ch_cmd_v", 32'(ch_cmd_v), 32'(exp_cv));
        if (cv) check("ch_cmd_data", 32'(ch_cmd[sel]), 32'(cmd));
        check("resp_v", 32'(resp_v), 32'(exp_rv));
        if (exp_rv) check("resp_order", 32'(resp), 32'(f.d ^ RESP_X));
        check("ch_resp_yumi", 32'(ch_resp_yumi), 32'(exp_y));
        check("outstanding0", 32'(outst[0]), 32'(n0));
        check("outstanding1", 32'(outst[1]), 32'(n1));
        check("idle", 32'(idle), 32'(exp_q.size() == 0));
        acc = cv && exp_rdy;
        if (pop) begin
            void'(exp_q.pop_front());
            if (f.ch) void'(br1.pop_front());
            else void'(br0.pop_front());
        end
        if (acc) begin
            exp_q.push_back({sel, cmd});
            nb.d   = cmd;
            nb.due = cyc + int'($urandom_range(lat_hi[sel], lat_lo[sel]));
            if (sel) br1.push_back(nb);
            else br0.push_back(nb);
            accepted++;
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            run_cycle(1'b0, '0, 2'b11, 100);
            n++;
        end
        @(negedge clk);
        resp_yumi = 1'b0;
        #1;
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        lat_lo = '{1, 1};
        lat_hi = '{1, 1};

        // Reset state, with every input trying to provoke a handshake.
        cmd_v      = 1'b1;
        addr       = 40'h40;
        ch_cmd_rdy = 2'b11;
        ch_resp_v  = 2'b11;
        resp_yumi  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_rdy), 32'd0);
        check("rst_ch_cmd_v", 32'(ch_cmd_v), 32'd0);
        check("rst_resp_v", 32'(resp_v), 32'd0);
        check("rst_ch_yumi", 32'(ch_resp_yumi), 32'd0);
        check("rst_outstanding", 32'(outst), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        cmd_v     = 1'b0;
        ch_resp_v = 2'b00;
        resp_yumi = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_cycle(1'b0, '0, 2'b11, 0);

        // Alternating blocks; channel 1 answers quickly, channel 0 slowly.
        lat_lo = '{10, 2};
        lat_hi = '{10, 2};
        run_cycle(1'b1, 40'h00, 2'b11, 0);
        run_cycle(1'b1, 40'h40, 2'b11, 0);
        run_cycle(1'b1, 40'h80, 2'b11, 0);
        run_cycle(1'b1, 40'hC0, 2'b11, 0);
        @(negedge clk);
        cmd_v = 1'b0;
        #1;
        check("alt_outstanding0", 32'(outst[0]), 32'd2);
        check("alt_outstanding1", 32'(outst[1]), 32'd2);
        drain("alt_drain_idle", 200);

        // Fill to capacity, then pop while a command waits: not accepted until next cycle.
        lat_lo = '{1, 1};
        lat_hi = '{1, 1};
        for (int i = 0; i < EL; i++) begin
            run_cycle(1'b1, {8'($urandom), $urandom}, 2'b11, 0);
        end
        run_cycle(1'b1, 40'h40, 2'b11, 0);
        check("full_ready_low", 32'(cmd_rdy), 32'd0);
        run_cycle(1'b1, 40'h40, 2'b11, 100);
        run_cycle(1'b1, 40'h40, 2'b11, 0);
        drain("full_drain_idle", 200);

        // Channel 1 not ready: the 0x40 command blocks the stream behind it.
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 40'h40, 2'b01, 0);
        end
        run_cycle(1'b1, 40'h40, 2'b11, 0);
        run_cycle(1'b1, 40'h00, 2'b11, 0);
        drain("block_drain_idle", 200);

        // Asynchronous reset with five commands outstanding.
        lat_lo = '{50, 50};
        lat_hi = '{50, 50};
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, 40'(i * 64), 2'b11, 0);
        end
        @(negedge clk);
        cmd_v      = 1'b1;
        addr       = 40'h40;
        ch_cmd_rdy = 2'b11;
        ch_resp_v  = 2'b11;
        #1;
        check("pre_reset_outstanding", 32'(outst[0]) + 32'(outst[1]), 32'd5);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_cmd_ready", 32'(cmd_rdy), 32'd0);
        check("async_ch_cmd_v", 32'(ch_cmd_v), 32'd0);
        check("async_resp_v", 32'(resp_v), 32'd0);
        check("async_ch_yumi", 32'(ch_resp_yumi), 32'd0);
        check("async_outstanding", 32'(outst), 32'd0);
        check("async_idle", 32'(idle), 32'd1);
        exp_q.delete();
        br0.delete();
        br1.delete();
        cmd_v     = 1'b0;
        ch_resp_v = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_cycle(1'b0, '0, 2'b11, 0);
        run_cycle(1'b0, '0, 2'b11, 0);

        // Random traffic: 100 commands, per-channel latencies 1..20.
        lat_lo   = '{1, 1};
        lat_hi   = '{20, 20};
        accepted = 0;
        for (int n = 0; n < 6000 && (accepted < 100 || exp_q.size() > 0); n++) begin
            run_cycle((accepted < 100) && ($urandom_range(3) != 0),
                      {8'($urandom), $urandom},
                      {($urandom_range(3) != 0), ($urandom_range(3) != 0)},
                      70);
        end
        @(negedge clk);
        resp_yumi = 1'b0;
        cmd_v     = 1'b0;
        #1;
        check("rand_all_accepted", 32'(accepted), 32'd100);
        check("rand_end_outstanding0", 32'(outst[0]), 32'd0);
        check("rand_end_outstanding1", 32'(outst[1]), 32'd0);
        check("rand_end_idle", 32'(idle), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
